// File: rtl/conv_line_sched.sv
// conv_line_sched: steers pixels into four rotating line buffers and reads three of them in lockstep as 3x3 windows.
// Optional WINDOW_REG_EN registers o_window/o_window_valid (1-cycle latency); otherwise they are combinational.
module conv_line_sched #(
   parameter int LINE_W      = 512,
   parameter int RD_PER_LINE = LINE_W - 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_pixel_data,
   input  logic        i_pixel_valid,
   output logic        o_pixel_ready,
   output logic [7:0]  o_lb_wr_data,
   output logic [3:0]  o_lb_wr_valid,
   input  logic [95:0] i_lb_rd_data,
   output logic [3:0]  o_lb_rd_en,
   output logic [71:0] o_window,
   output logic        o_window_valid,
   output logic        o_intr
);
   localparam int CW = $clog2(LINE_W);
   localparam logic [CW-1:0] LAST_COL = CW'(LINE_W - 1);
   localparam logic [CW-1:0] LAST_RD  = CW'(RD_PER_LINE - 1);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RD   = 1'b1;

   logic [0:0]    r_state;
   logic [CW-1:0] r_wr_col;
   logic [CW-1:0] r_rd_cnt;
   logic [1:0]    r_wr_sel;
   logic [1:0]    r_rd_sel;
   logic [2:0]    r_lines_full;
   logic          r_intr;
   logic          w_acc;
   logic          w_wr_wrap;
   logic          w_rd;
   logic          w_row_end;
   logic [23:0]   w_lb [4];
   logic [71:0]   w_win;

   assign o_pixel_ready = r_lines_full != 3'd4;
   assign w_acc         = i_pixel_valid & o_pixel_ready;
   assign w_wr_wrap     = w_acc && r_wr_col == LAST_COL;
   assign w_rd          = r_state == S_RD;
   assign w_row_end     = w_rd && r_rd_cnt == LAST_RD;
   assign o_lb_wr_data  = i_pixel_data;
   assign o_lb_wr_valid = w_acc ? 4'b1 << r_wr_sel : 4'b0;
   assign o_lb_rd_en    = w_rd ? (4'b1 << r_rd_sel) | (4'b1 << (r_rd_sel + 2'd1)) | (4'b1 << (r_rd_sel + 2'd2)) : 4'b0;
   assign o_intr        = r_intr;

   genvar g;
   for (g = 0; g < 4; g++) begin : g_lb
      assign w_lb[g] = i_lb_rd_data[24*g +: 24];
   end

   // row0 is the oldest line, held in the buffer at rd_sel
   assign w_win = w_rd ? {w_lb[r_rd_sel + 2'd2], w_lb[r_rd_sel + 2'd1], w_lb[r_rd_sel]} : 72'b0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_wr_col     <= '0;
         r_wr_sel     <= 2'd0;
         r_rd_sel     <= 2'd0;
         r_rd_cnt     <= '0;
         r_lines_full <= 3'd0;
         r_intr       <= 1'b0;
      end else begin
         if (w_acc) r_wr_col <= w_wr_wrap ? '0 : r_wr_col + 1'b1;
         if (w_wr_wrap) r_wr_sel <= r_wr_sel + 2'd1;
         r_lines_full <= r_lines_full + {2'b0, w_wr_wrap} - {2'b0, w_row_end};
         r_intr       <= w_row_end;
         if (!w_rd) begin
            r_rd_cnt <= '0;
            if (r_lines_full >= 3'd3) r_state <= S_RD;
         end else begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_row_end) begin
               r_state  <= S_IDLE;
               r_rd_sel <= r_rd_sel + 2'd1;
            end
         end
      end
   end

`ifdef WINDOW_REG_EN
   logic [71:0] r_window;
   logic        r_window_valid;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_window       <= 72'b0;
         r_window_valid <= 1'b0;
      end else begin
         r_window       <= w_win;
         r_window_valid <= w_rd;
      end
   end
   assign o_window       = r_window;
   assign o_window_valid = r_window_valid;
`else
   assign o_window       = w_win;
   assign o_window_valid = |o_lb_rd_en;
`endif
endmodule
